instr_encoder: RTL and testbench

- Inverse of the immediate generator: packs opcode, register, funct and 32-bit immediate fields into one RV32I instruction word.
- Immediate bit-scattering for R/I/S/B/U/J formats is exactly the inverse of the decoder's reassembly.
- Two-stage valid/ready pipeline. Sits between the test-program sequencer / boot loader and the instruction-memory write port.
- Provides the round-trip reference for verifying the decode path.

---
 rtl/instr_encoder.sv | 91 +++++++++
 tb/tb_instr_encoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields into an instruction word through a 2-stage valid/ready pipe; define IMM_RANGE_CHK_EN to flag unencodable immediates on err_imm
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err_fmt,
  output logic             err_imm,
  output logic [CNT_W-1:0] enc_count
);
  logic        s1_v;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_op;
  logic [6:0]  s1_f7;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_f3;
  logic [31:0] s1_imm;
  logic        in_acc;
  logic        s2_ld;
  logic [31:0] enc;
  logic        bad_fmt;
  logic        bad_imm;
  assign in_ready = !s1_v || !out_valid || out_ready;
  assign in_acc   = in_valid && in_ready;
  assign s2_ld    = s1_v && (!out_valid || out_ready);
  assign bad_fmt  = s1_fmt > 3'd5;
  assign enc =
    s1_fmt == 3'd0 ? {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op} :
    s1_fmt == 3'd1 ? {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op} :
    s1_fmt == 3'd2 ? {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op} :
    s1_fmt == 3'd3 ? {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:1], s1_imm[11], s1_op} :
    s1_fmt == 3'd4 ? {s1_imm[31:12], s1_rd, s1_op} :
    s1_fmt == 3'd5 ? {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op} :
                     32'h0000_0013;
`ifdef IMM_RANGE_CHK_EN
  assign bad_imm =
    (s1_fmt == 3'd1 || s1_fmt == 3'd2) ? !(&s1_imm[31:11] || !(|s1_imm[31:11])) :
    s1_fmt == 3'd3 ? !(&s1_imm[31:12] || !(|s1_imm[31:12])) || s1_imm[0] :
    s1_fmt == 3'd4 ? |s1_imm[11:0] :
    s1_fmt == 3'd5 ? !(&s1_imm[31:20] || !(|s1_imm[31:20])) || s1_imm[0] :
                     1'b0;
`else
  assign bad_imm = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
      instr     <= '0;
      err_fmt   <= 1'b0;
      err_imm   <= 1'b0;
      enc_count <= '0;
    end else begin
      s1_v      <= in_acc || (s1_v && !s2_ld);
      out_valid <= s2_ld || (out_valid && !out_ready);
      if (s2_ld) begin
        instr   <= enc;
        err_fmt <= bad_fmt;
        err_imm <= bad_imm;
      end
      if (out_valid && out_ready) enc_count <= enc_count + 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (in_acc) begin
      s1_fmt <= fmt;
      s1_op  <= opcode;
      s1_f7  <= funct7;
      s1_rd  <= rd;
      s1_rs1 <= rs1;
      s1_rs2 <= rs2;
      s1_f3  <= funct3;
      s1_imm <= imm;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with a scoreboarded field-packing model for instr_encoder
module tb_instr_encoder;
  localparam int CNT_W = 16;
  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [2:0]       fmt = '0;
  logic [6:0]       opcode = '0;
  logic [4:0]       rd = '0;
  logic [4:0]       rs1 = '0;
  logic [4:0]       rs2 = '0;
  logic [2:0]       funct3 = '0;
  logic [6:0]       funct7 = '0;
  logic [31:0]      imm = '0;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      instr;
  logic             err_fmt;
  logic             err_imm;
  logic [CNT_W-1:0] enc_count;
  int vectors = 0;
  int miscompares = 0;
  instr_encoder #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err_fmt(err_fmt), .err_imm(err_imm), .enc_count(enc_count)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [31:0] i;
    logic        ef;
    logic        ei;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [31:0] got[$];
  logic        got_ef[$];
  logic        got_ei[$];
  int          n_model = 0;
  logic        held_v = 1'b0;
  logic [31:0] held_i;
  logic [1:0]  held_e;
`ifdef IMM_RANGE_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  function automatic exp_t model(input logic [2:0] f, input logic [6:0] op, input logic [6:0] f7,
                                 input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                                 input logic [2:0] f3, input logic [31:0] im);
    exp_t   r;
    longint sv;
    logic [31:0] base;
    sv   = longint'($signed(im));
    base = (32'(a) << 15) | (32'(f3) << 12) | 32'(op);
    r.ef = 1'b0;
    r.ei = 1'b0;
    case (f)
      3'd0: r.i = (32'(f7) << 25) | (32'(b) << 20) | base | (32'(d) << 7);
      3'd1: r.i = ((im & 32'hFFF) << 20) | base | (32'(d) << 7);
      3'd2: r.i = (((im >> 5) & 32'h7F) << 25) | (32'(b) << 20) | base | ((im & 32'h1F) << 7);
      3'd3: r.i = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(b) << 20) | base
                  | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
      3'd4: r.i = (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
      3'd5: r.i = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 32'h1) << 20)
                  | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
      default: begin
        r.i  = 32'h0000_0013;
        r.ef = 1'b1;
      end
    endcase
    if (CHK && f != 3'd0 && f < 3'd6)
      r.ei = (f == 3'd1 || f == 3'd2) ? (sv < -64'sd2048 || sv > 64'sd2047) :
             f == 3'd3 ? (sv < -64'sd4096 || sv > 64'sd4095 || im[0]) :
             f == 3'd5 ? (sv < -64'sd1048576 || sv > 64'sd1048575 || im[0]) :
             (im % 32'd4096 != 0);
    return r;
  endfunction
  function automatic logic [31:0] dec_b(input logic [31:0] i);
    logic [12:0] t;
    t = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    return {{19{t[12]}}, t};
  endfunction
  function automatic logic [31:0] dec_j(input logic [31:0] i);
    logic [20:0] t;
    t = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    return {{11{t[20]}}, t};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (RST) begin
      q.delete();
      n_model = 0;
      held_v = 1'b0;
    end else begin
      chk("enc_count", 32'(enc_count), n_model);
      if (held_v) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_instr", instr, held_i);
        chk("hold_err", 32'({err_fmt, err_imm}), 32'(held_e));
      end
      held_v = out_valid && !out_ready;
      held_i = instr;
      held_e = {err_fmt, err_imm};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got %h expected none", instr);
        end else begin
          e = q.pop_front();
          chk("instr", instr, e.i);
          chk("err_fmt", 32'(err_fmt), 32'(e.ef));
          chk("err_imm", 32'(err_imm), 32'(e.ei));
        end
        got.push_back(instr);
        got_ef.push_back(err_fmt);
        got_ei.push_back(err_imm);
        n_model++;
      end
      if (in_valid && in_ready) q.push_back(model(fmt, opcode, funct7, rd, rs1, rs2, funct3, imm));
    end
  end
  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [6:0] f7, input logic [4:0] d,
                       input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3, input logic [31:0] im);
    fmt = f; opcode = op; funct7 = f7; rd = d; rs1 = a; rs2 = b; funct3 = f3; imm = im;
    in_valid = 1'b1;
  endtask
  task automatic wait_acc();
    int t;
    t = 0;
    @(negedge CLK);
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [6:0] f7, input logic [4:0] d,
                      input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3, input logic [31:0] im);
    drive(f, op, f7, d, a, b, f3, im);
    wait_acc();
  endtask
  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && t < 40) begin
      @(posedge CLK);
      t++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask
  initial begin
    exp_t m;
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t m;
    m = model(3'd1, 7'h13, 7'h00, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF);
    chk("model_I", m.i, 32'hFFF3_0293);
    m = model(3'd3, 7'h63, 7'h00, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);
    chk("model_B", m.i, 32'h0020_8463);
    m = model(3'd5, 7'h6F, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
    chk("model_J", m.i, 32'hFFDF_F0EF);
    m = model(3'd2, 7'h23, 7'h00, 5'd0, 5'd2, 5'd5, 3'd2, 32'hFFFF_FFFC);
    chk("model_S", m.i, 32'hFE51_2E23);
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_instr", instr, 0);
    chk("rst_errs", 32'({err_fmt, err_imm}), 0);
    chk("rst_count", 32'(enc_count), 0);
    @(posedge CLK);
    #1;
    send(3'd1, 7'h13, 7'h00, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("lat_n1_valid", 32'(out_valid), 0);
    @(negedge CLK);
    chk("lat_n2_valid", 32'(out_valid), 1);
    chk("lat_n2_instr", instr, 32'hFFF3_0293);
    chk("lat_n2_errs", 32'({err_fmt, err_imm}), 0);
    @(negedge CLK);
    chk("lat_count", 32'(enc_count), 1);
    @(posedge CLK);
    #1;
    send(3'd3, 7'h63, 7'h00, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);
    send(3'd5, 7'h6F, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
    send(3'd0, 7'h33, 7'h20, 5'd1, 5'd2, 5'd3, 3'd0, 32'hDEAD_BEEF);
    send(3'd2, 7'h23, 7'h00, 5'd0, 5'd2, 5'd5, 3'd2, 32'hFFFF_FFFC);
    send(3'd4, 7'h37, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    send(3'd7, 7'h33, 7'h7F, 5'd3, 5'd3, 5'd3, 3'd7, 32'h1234_5678);
    send(3'd1, 7'h13, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
    send(3'd4, 7'h37, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h1234_5678);
    send(3'd5, 7'h6F, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0003);
    drain();
    chk("stream_beats", got.size(), 10);
    chk("B_instr", got[1], 32'h0020_8463);
    chk("B_roundtrip", dec_b(got[1]), 32'd8);
    chk("J_instr", got[2], 32'hFFDF_F0EF);
    chk("J_roundtrip", dec_j(got[2]), 32'hFFFF_FFFC);
    chk("R_instr", got[3], 32'h4031_00B3);
    chk("S_instr", got[4], 32'hFE51_2E23);
    chk("U_instr", got[5], 32'h1234_5537);
    chk("bad_fmt_instr", got[6], 32'h0000_0013);
    chk("bad_fmt_flag", 32'(got_ef[6]), 1);
    chk("bad_fmt_errimm", 32'(got_ei[6]), 0);
    chk("I800_hi", got[7] >> 20, 32'h800);
    chk("I800_errimm", 32'(got_ei[7]), 32'(CHK));
    chk("Ulow_instr", got[8], 32'h1234_5537);
    chk("Ulow_errimm", 32'(got_ei[8]), 32'(CHK));
    chk("Jodd_errimm", 32'(got_ei[9]), 32'(CHK));
    chk("R_errimm", 32'(got_ei[3]), 0);
    do_reset();
    got.delete(); got_ef.delete(); got_ei.delete();
    out_ready = 1'b0;
    send(3'd1, 7'h13, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    send(3'd1, 7'h13, 7'h00, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
    drive(3'd1, 7'h13, 7'h00, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3);
    @(negedge CLK);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_instr_A", instr, 32'h0010_0093);
    @(negedge CLK);
    chk("bp_in_ready2", 32'(in_ready), 0);
    chk("bp_valid", 32'(out_valid), 1);
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    wait_acc();
    drain();
    chk("bp_beats", got.size(), 3);
    chk("bp_A", got[0], 32'h0010_0093);
    chk("bp_B", got[1], 32'h0020_0113);
    chk("bp_C", got[2], 32'h0030_0193);
    chk("bp_count", 32'(enc_count), 3);
    out_ready = 1'b0;
    send(3'd1, 7'h13, 7'h00, 5'd7, 5'd0, 5'd0, 3'd0, 32'd7);
    send(3'd1, 7'h13, 7'h00, 5'd8, 5'd0, 5'd0, 3'd0, 32'd8);
    in_valid = 1'b0;
    @(posedge CLK);
    #1;
    do_reset();
    got.delete(); got_ef.delete(); got_ei.delete();
    @(negedge CLK);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_count", 32'(enc_count), 0);
    chk("mid_rst_instr", instr, 0);
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    send(3'd1, 7'h13, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 32'd5);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("post_rst_n1_valid", 32'(out_valid), 0);
    @(negedge CLK);
    chk("post_rst_n2_valid", 32'(out_valid), 1);
    chk("post_rst_instr", instr, 32'h0050_0293);
    drain();
    chk("post_rst_beats", got.size(), 1);
    chk("post_rst_count", 32'(enc_count), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
